usb_rx_packet: RTL and testbench

Packet-level receiver that sits directly downstream of the JK/NRZI bit decoder. It assembles decoded, de-stuffed bits into bytes (LSB first) and presents them as a byte stream. It validates the PID and checks CRC5 or CRC16 according to packet type. At end of packet it reports one status word to the protocol engine.

---
 rtl/usb_rx_packet.sv | 183 ++++++++++++++++++
 tb/tb_usb_rx_packet.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet.sv
// USB packet receiver: assembles de-stuffed bits into bytes, validates the PID,
// checks CRC5/CRC16 by packet type and reports one status word per packet.
module usb_rx_packet #(
  parameter int unsigned MAX_PKT_BYTES = 1026
) (
  input  logic       clk48,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       bus_sop,
  input  logic       bus_eop,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       byte_is_pid,
  output logic [3:0] pid,
  output logic       pkt_end,
  output logic       pkt_ok,
  output logic       pid_err,
  output logic       crc_err,
  output logic       align_err,
  output logic       len_err
);

  localparam int unsigned CNT_W = $clog2(MAX_PKT_BYTES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_BYTES);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_PKT_BYTES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;
  typedef enum logic [1:0] {K_NONE, K_TOKEN, K_DATA, K_HS} kind_t;

  state_t           state;
  kind_t            kind;
  logic [7:0]       sr;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic [4:0]       c5;
  logic [15:0]      c16;
  logic             crc_good;
  logic             pid_bad;
  logic             len_ovf;
  logic             align_bad;

  logic [7:0]  byte_c;
  logic [2:0]  bit_cnt_c;
  logic [4:0]  c5_c;
  logic [15:0] c16_c;
  kind_t       kind_c;
  logic        pid_bad_c;
  logic        start_c;
  logic        empty_c;
  logic        len_bad_c;
  logic        crc_bad_c;
  logic        pid_fail_c;

  // Next-byte, CRC step and PID decode for the bit currently offered.
  always_comb begin
    byte_c    = {bit_in, sr[7:1]};
    bit_cnt_c = bit_cnt + 3'(bit_valid);
    c5_c      = {c5[3:0], 1'b0} ^ ((bit_in ^ c5[4]) ? 5'b00101 : 5'b00000);
    c16_c     = {c16[14:0], 1'b0} ^ ((bit_in ^ c16[15]) ? 16'h8005 : 16'h0000);
    start_c   = bus_sop && (state != S_DONE);
    kind_c    = K_NONE;
    pid_bad_c = (byte_c[7:4] != ~byte_c[3:0]);
    case (byte_c[1:0])
      2'b01:   kind_c = K_TOKEN;
      2'b11:   kind_c = K_DATA;
      2'b10:   kind_c = K_HS;
      default: begin
        if (byte_c[3:0] == 4'b0100) kind_c = K_TOKEN;
        else                        pid_bad_c = 1'b1;
      end
    endcase
  end

  // End-of-packet status terms; an empty packet reports only a length error.
  always_comb begin
    empty_c   = (byte_cnt == '0);
    len_bad_c = empty_c || len_ovf;
    case (kind)
      K_TOKEN: if (byte_cnt != CNT_W'(3)) len_bad_c = 1'b1;
      K_HS:    if (byte_cnt != CNT_W'(1)) len_bad_c = 1'b1;
      K_DATA:  if (byte_cnt < CNT_W'(3))  len_bad_c = 1'b1;
      default: ;
    endcase
    crc_bad_c  = !empty_c && (kind == K_TOKEN || kind == K_DATA) && !crc_good;
    pid_fail_c = !empty_c && pid_bad;
  end

  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      kind        <= K_NONE;
      sr          <= 8'h00;
      bit_cnt     <= 3'd0;
      byte_cnt    <= '0;
      c5          <= 5'h1F;
      c16         <= 16'hFFFF;
      crc_good    <= 1'b0;
      pid_bad     <= 1'b0;
      len_ovf     <= 1'b0;
      align_bad   <= 1'b0;
      byte_out    <= 8'h00;
      byte_valid  <= 1'b0;
      byte_is_pid <= 1'b0;
      pid         <= 4'h0;
      pkt_end     <= 1'b0;
      pkt_ok      <= 1'b0;
      pid_err     <= 1'b0;
      crc_err     <= 1'b0;
      align_err   <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      byte_is_pid <= 1'b0;
      pkt_end     <= 1'b0;
      pkt_ok      <= 1'b0;
      pid_err     <= 1'b0;
      crc_err     <= 1'b0;
      align_err   <= 1'b0;
      len_err     <= 1'b0;
      if (start_c) begin
        // A start pulse in RECV silently abandons the packet in progress.
        state     <= S_RECV;
        kind      <= K_NONE;
        sr        <= 8'h00;
        bit_cnt   <= 3'd0;
        byte_cnt  <= '0;
        c5        <= 5'h1F;
        c16       <= 16'hFFFF;
        crc_good  <= 1'b0;
        pid_bad   <= 1'b0;
        len_ovf   <= 1'b0;
        align_bad <= 1'b0;
      end else begin
        case (state)
          S_RECV: begin
            if (bit_valid) begin
              sr      <= byte_c;
              bit_cnt <= bit_cnt_c;
              if (byte_cnt != '0) begin
                c5  <= c5_c;
                c16 <= c16_c;
              end
              if (bit_cnt == 3'd7) begin
                if (byte_cnt < CNT_MAX) begin
                  byte_out    <= byte_c;
                  byte_valid  <= 1'b1;
                  byte_is_pid <= (byte_cnt == '0);
                end else begin
                  len_ovf <= 1'b1;
                end
                if (byte_cnt != CNT_SAT) byte_cnt <= byte_cnt + CNT_W'(1);
                if (byte_cnt == '0) begin
                  pid     <= byte_c[3:0];
                  kind    <= kind_c;
                  pid_bad <= pid_bad_c;
                end else begin
                  crc_good <= (kind == K_DATA) ? (c16_c == 16'h800D) : (c5_c == 5'b01100);
                end
              end
            end
            if (bus_eop) begin
              // One trailing bit may come from the SE0 sample and is tolerated.
              align_bad <= (bit_cnt_c > 3'd1);
              state     <= S_DONE;
            end
          end
          S_DONE: begin
            pkt_end   <= 1'b1;
            pid_err   <= pid_fail_c;
            crc_err   <= crc_bad_c;
            align_err <= align_bad;
            len_err   <= len_bad_c;
            pkt_ok    <= !(pid_fail_c || crc_bad_c || align_bad || len_bad_c);
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_packet.sv
// Directed bench for usb_rx_packet: table of packets with expected status,
// plus sequences for restart, same-cycle start/bit, reset abort and overflow.
module tb_usb_rx_packet;

  logic       clk48 = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic       bus_sop;
  logic       bus_eop;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_is_pid;
  logic [3:0] pid;
  logic       pkt_end;
  logic       pkt_ok;
  logic       pid_err;
  logic       crc_err;
  logic       align_err;
  logic       len_err;

  usb_rx_packet #(.MAX_PKT_BYTES(1026)) dut (
    .clk48(clk48), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bus_sop(bus_sop), .bus_eop(bus_eop), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_is_pid(byte_is_pid), .pid(pid),
    .pkt_end(pkt_end), .pkt_ok(pkt_ok), .pid_err(pid_err), .crc_err(crc_err),
    .align_err(align_err), .len_err(len_err)
  );

  always #5 clk48 = ~clk48;

  typedef struct {
    logic [7:0] b [6];
    int         n;
    int         extra;
    bit         eop_last;
    bit         sop_bit;
    logic [4:0] st;    // {ok, pid_err, crc_err, align_err, len_err}
    logic [4:0] mask;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         end_cnt = 0;
  logic [7:0] rx_q [$];
  bit         rxp_q [$];

  always @(negedge clk48) begin
    if (byte_valid) begin
      rx_q.push_back(byte_out);
      rxp_q.push_back(byte_is_pid);
    end
    if (pkt_end) end_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk48);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit with_eop);
    bit_in    = b;
    bit_valid = 1'b1;
    bus_eop   = with_eop;
    cyc();
    bit_valid = 1'b0;
    bus_eop   = 1'b0;
    if (!with_eop) repeat (3) cyc();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int j = 0; j < 8; j++) send_bit(v[j], 1'b0);
  endtask

  // Called right after the cycle that presented bus_eop; returns status at pkt_end.
  task automatic wait_end(input string nm, output logic [4:0] st);
    int lat = 0;
    st = 5'h00;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk48);
      if (pkt_end) begin
        lat = k;
        st  = {pkt_ok, pid_err, crc_err, align_err, len_err};
        break;
      end
    end
    chk({nm, " pkt_end latency"}, 32'(lat), 32'd2);
    cyc();
  endtask

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, b4, b5,
                              input int n, extra, input bit el, sb,
                              input logic [4:0] st, mask);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4; v.b[5] = b5;
    v.n = n; v.extra = extra; v.eop_last = el; v.sop_bit = sb; v.st = st; v.mask = mask;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int         total;
    logic [7:0] cur;
    logic       b;
    logic [4:0] st;
    logic [3:0] exp_pid;
    rx_q.delete();
    rxp_q.delete();
    bus_sop   = 1'b1;
    bit_valid = v.sop_bit;
    bit_in    = 1'b1;
    cyc();
    bus_sop   = 1'b0;
    bit_valid = 1'b0;
    cyc();
    total = 8 * v.n + v.extra;
    for (int i = 0; i < total; i++) begin
      if (i < 8 * v.n) begin
        cur = v.b[i / 8];
        b   = cur[i % 8];
      end else begin
        b = 1'b0;
      end
      send_bit(b, v.eop_last && (i == total - 1));
    end
    if (!v.eop_last || total == 0) begin
      bus_eop = 1'b1;
      cyc();
      bus_eop = 1'b0;
    end
    wait_end(nm, st);
    repeat (2) cyc();
    chk({nm, " status"}, 32'(st & v.mask), 32'(v.st & v.mask));
    chk({nm, " strobes"}, 32'(rx_q.size()), 32'(v.n));
    for (int k = 0; k < v.n && k < rx_q.size(); k++) begin
      chk({nm, " byte"}, 32'(rx_q[k]), 32'(v.b[k]));
      chk({nm, " is_pid"}, 32'(rxp_q[k]), (k == 0) ? 32'd1 : 32'd0);
    end
    if (v.n > 0) begin
      cur     = v.b[0];
      exp_pid = cur[3:0];
      chk({nm, " pid"}, 32'(pid), 32'(exp_pid));
    end
  endtask

  vec_t vt [17];
  vec_t ack;

  initial begin
    logic [4:0] st;
    int         e0;
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; bus_sop = 1'b0; bus_eop = 1'b0;
    repeat (2) cyc();
    chk("reset outputs", 32'({byte_out, byte_valid, byte_is_pid, pid, pkt_end, pkt_ok,
                              pid_err, crc_err, align_err, len_err}), 32'd0);
    reset = 1'b0;
    repeat (2) cyc();

    vt[0]  = mk(8'hD2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b10000, 5'h1F);
    vt[1]  = mk(8'h2D, 8'h00, 8'h10, 0, 0, 0, 3, 0, 0, 0, 5'b10000, 5'h1F);
    vt[2]  = mk(8'h2D, 8'h00, 8'h11, 0, 0, 0, 3, 0, 0, 0, 5'b00100, 5'h1F);
    vt[3]  = mk(8'hC3, 8'h00, 8'h00, 0, 0, 0, 3, 0, 0, 0, 5'b10000, 5'h1F);
    vt[4]  = mk(8'h4B, 8'h00, 8'h00, 0, 0, 0, 3, 0, 0, 0, 5'b10000, 5'h1F);
    vt[5]  = mk(8'hC3, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 6, 0, 0, 0, 5'b00100, 5'h1F);
    vt[6]  = mk(8'hFF, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b01000, 5'b11000);
    vt[7]  = mk(8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b01000, 5'b11000);
    vt[8]  = mk(8'h2D, 8'h00, 0, 0, 0, 0, 2, 0, 0, 0, 5'b00001, 5'b10001);
    vt[9]  = mk(8'hD2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5'b10000, 5'h1F);
    vt[10] = mk(8'hD2, 0, 0, 0, 0, 0, 1, 3, 0, 0, 5'b00010, 5'h1F);
    vt[11] = mk(8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 5'h1F);
    vt[12] = mk(8'hD2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 5'b10000, 5'h1F);
    vt[13] = mk(8'hD2, 0, 0, 0, 0, 0, 1, 1, 1, 0, 5'b10000, 5'h1F);
    vt[14] = mk(8'hD2, 0, 0, 0, 0, 0, 1, 2, 1, 0, 5'b00010, 5'h1F);
    vt[15] = mk(8'hD2, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5'b10000, 5'h1F);
    vt[16] = mk(8'hB4, 8'h00, 8'h10, 0, 0, 0, 3, 0, 0, 0, 5'b10000, 5'h1F);
    ack    = vt[0];

    for (int i = 0; i < 17; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Restart mid-packet: only the second packet may report.
    e0 = end_cnt;
    bus_sop = 1'b1; cyc(); bus_sop = 1'b0; cyc();
    for (int j = 0; j < 5; j++) send_bit(1'b1, 1'b0);
    run_vec(ack, "restart");
    chk("restart pkt_end count", 32'(end_cnt - e0), 32'd1);

    // Reset after 12 bits of a token aborts at once with no status.
    e0 = end_cnt;
    bus_sop = 1'b1; cyc(); bus_sop = 1'b0; cyc();
    send_byte(8'h2D);
    for (int j = 0; j < 4; j++) send_bit(1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("reset abort outputs", 32'({byte_out, byte_valid, byte_is_pid, pid, pkt_end, pkt_ok,
                                    pid_err, crc_err, align_err, len_err}), 32'd0);
    repeat (2) cyc();
    reset = 1'b0;
    bus_eop = 1'b1; cyc(); bus_eop = 1'b0;
    repeat (20) cyc();
    chk("reset no pkt_end", 32'(end_cnt - e0), 32'd0);
    run_vec(ack, "after reset");

    // Oversized DATA0: bytes past the limit are dropped and flagged.
    rx_q.delete();
    rxp_q.delete();
    bus_sop = 1'b1; cyc(); bus_sop = 1'b0; cyc();
    send_byte(8'hC3);
    for (int j = 0; j < 1026; j++) send_byte(8'h00);
    bus_eop = 1'b1; cyc(); bus_eop = 1'b0;
    wait_end("overflow", st);
    chk("overflow strobes", 32'(rx_q.size()), 32'd1026);
    chk("overflow status", 32'(st & 5'b10001), 32'(5'b00001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
